vadd_stream_arbiter: RTL and testbench
======================================

// Module: vadd_stream_arbiter
// PURPOSE
//  Shares one pipelined vector-add datapath between C_NUM_REQ AXI4-Stream requesters.
//  - Round-robin, packet-granular arbitration: a grant is held from first beat to tlast.
//  - Forwards the granted stream through one output register stage.
//  - Presents the winner's add constant beat-aligned with its data.
//  - Sits between the per-requester read masters and the adder's s_axis port.
// PARAMETERS
//  C_NUM_REQ           4    number of requesters (2..16)
//  C_AXIS_TDATA_WIDTH  512  data width of every stream
//  C_ADDER_BIT_WIDTH   32   width of each per-requester constant
//  C_MAX_BURST_BEATS   256  beat limit per grant (used only with ARB_BEAT_LIMIT_EN)
//  LP_ID_W = clog2(C_NUM_REQ), min 1 (localparam)
// PORTS
//  aclk            in   1            single clock for all logic
//  aresetn         in   1            synchronous, active-low reset
//  ctrl_constants  in   N*CB         constant of requester i at [i*CB +: CB]
//  s_axis_tvalid   in   N            per-requester valid
//  s_axis_tready   out  N            per-requester ready
//  s_axis_tdata    in   N*W          requester i at [i*W +: W]
//  s_axis_tkeep    in   N*W/8        requester i at [i*W/8 +: W/8]
//  s_axis_tlast    in   N            per-requester end of packet
//  m_axis_tvalid   out  1            to adder
//  m_axis_tready   in   1            from adder
//  m_axis_tdata    out  W            granted data
//  m_axis_tkeep    out  W/8          granted keep
//  m_axis_tlast    out  1            granted last
//  m_axis_tdest    out  LP_ID_W      index of the requester that produced the beat
//  m_ctrl_constant out  CB           constant of the requester that produced the beat
//  arb_grant       out  N            one-hot current grant; 0 when idle
// BEHAVIOUR
//  Reset (aresetn=0 at posedge): state IDLE; rr pointer 0; beat count 0.
//   All outputs are 0 during reset: m_axis_tvalid, s_axis_tready, arb_grant, data fields.
//  Reset mid-packet: the in-flight beat in the output register is dropped.
//   After reset, arbitration restarts from requester 0.
//  FSM IDLE -> BUSY: any s_axis_tvalid high.
//   Winner = first valid at or after ptr, scanning ptr, ptr+1, ... with modulo C_NUM_REQ.
//   arb_grant is registered and takes the winner on the transition.
//  FSM BUSY: s_axis_tready[g] = ~m_valid_r | m_axis_tready; all other treadys stay 0.
//   An accepted beat loads the output register. tdata, tkeep and tlast are copied.
//   tdest = g; m_ctrl_constant = ctrl_constants[g] sampled in the same cycle.
//  FSM BUSY -> IDLE: on the accepted beat with tlast=1.
//   ptr <= g+1, with wrap at C_NUM_REQ-1 -> 0. arb_grant is cleared.
//   There is always exactly one IDLE cycle between grants.
//  Output register: m_valid_r is set by an accepted beat.
//   It is cleared by m_axis_tready with no new beat.
//   Simultaneous drain and load keeps it set, so throughput is 1 beat/cycle inside a grant.
//  Latency: an s beat accepted at cycle t appears on m at cycle t+1.
//  AXIS rules: m_axis_* are held stable while m_axis_tvalid=1 and m_axis_tready=0.
//   tvalid never depends combinationally on tready.
//  Requester drops tvalid mid-packet: the grant is held and bubbles are passed (no beats).
//  Only one requester valid: it wins every arbitration regardless of ptr.
//  ctrl_constants may change at any time; the value is captured per beat.
// CONFIGURATION
//  `define ARB_BEAT_LIMIT_EN:
//   A 9-bit-min beat counter counts accepted beats in BUSY.
//   The grant is released after C_MAX_BURST_BEATS beats even if tlast=0; ptr advances.
//   tlast is forwarded unmodified.
//  Without ARB_BEAT_LIMIT_EN: no counter is built; the grant is held strictly until tlast.
// STRUCTURE
//  vadd_arb_defs.vh:
//   - state localparams ST_IDLE=1'b0, ST_BUSY=1'b1
//   - clog2 function
//   - default C_MAX_BURST_BEATS
//  Sub-module vadd_rr_pick, combinational:
//   - inputs: req[N], ptr
//   - outputs: one-hot gnt and its index
//   - implemented as a double-width masked priority encode
//  Top level contains: FSM, grant/pointer registers, data mux, output register, optional counter.
// TESTING
//  1. Reset: hold aresetn=0 for 4 cycles with all tvalid=1.
//     -> All s_axis_tready, m_axis_tvalid and arb_grant are 0.
//     -> First grant after release goes to req0.
//  2. All 4 valid, each sends a 3-beat packet. Constants are 1, 2, 3, 4.
//     -> m order is req0, 1, 2, 3 with tdest 0..3.
//     -> m_ctrl_constant matches the source on every beat.
//     -> Exactly 1 idle cycle between packets.
//  3. Backpressure: m_axis_tready = 1,0,0,1 repeating during an 8-beat packet from req2.
//     -> No loss or duplication; m fields stable while stalled.
//     -> Single-beat and back-to-back cases pass at full rate when tready=1.
//  4. Wrap: only req3 then req0 request.
//     -> Grant goes to req3, then ptr wraps to 0 and req0 is granted.
//     -> A new req3 packet waiting behind req0 is served next.
//  5. Mid-packet reset: aresetn=0 on beat 2 of 5 from req1.
//     -> Outputs are 0 the next cycle.
//     -> After release, req0 (if valid) is granted before req1.
//  6. With ARB_BEAT_LIMIT_EN and C_MAX_BURST_BEATS=4: req0 sends 10 beats with no tlast, req1 also valid.
//     -> 4 beats from req0, then req1's packet, then req0 resumes.
//     -> Without the macro, all 10 beats of req0 come first.

Source files
------------

// File: rtl/vadd_stream_arbiter_pkg.sv
// Shared definitions for the vector-add stream arbiter: FSM state encodings,
// the default per-grant beat limit and a clog2 helper clamped to a minimum of 1.
package vadd_stream_arbiter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam int unsigned DEF_MAX_BURST_BEATS = 256;

  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vadd_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: the first request at or after ptr_i wins,
// found by priority-encoding a doubled request vector masked below ptr_i.
module vadd_rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  assign dbl    = {req_i, req_i};
  assign masked = dbl & ({(2*N){1'b1}} << ptr_i);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && masked[i]) begin
        found           = 1'b1;
        idx_o           = IDW'(i % N);
        gnt_o[i % N]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vadd_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one vector-add datapath through a
// single output register. Define ARB_BEAT_LIMIT_EN to cap each grant at C_MAX_BURST_BEATS.
module vadd_stream_arbiter
  import vadd_stream_arbiter_pkg::*;
#(
  parameter int unsigned C_NUM_REQ          = 4,
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_ADDER_BIT_WIDTH  = 32,
  parameter int unsigned C_MAX_BURST_BEATS  = DEF_MAX_BURST_BEATS,
  localparam int unsigned LP_ID_W           = clog2_min1(C_NUM_REQ),
  localparam int unsigned LP_KW             = C_AXIS_TDATA_WIDTH / 8
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0]  ctrl_constants,
  input  logic [C_NUM_REQ-1:0]                    s_axis_tvalid,
  output logic [C_NUM_REQ-1:0]                    s_axis_tready,
  input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_REQ*LP_KW-1:0]              s_axis_tkeep,
  input  logic [C_NUM_REQ-1:0]                    s_axis_tlast,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [LP_KW-1:0]                        m_axis_tkeep,
  output logic                                    m_axis_tlast,
  output logic [LP_ID_W-1:0]                      m_axis_tdest,
  output logic [C_ADDER_BIT_WIDTH-1:0]            m_ctrl_constant,
  output logic [C_NUM_REQ-1:0]                    arb_grant
);

  logic                          state_q, state_d;
  logic [C_NUM_REQ-1:0]          grant_q, grant_d;
  logic [LP_ID_W-1:0]            gidx_q, gidx_d;
  logic [LP_ID_W-1:0]            ptr_q, ptr_d;
  logic [C_NUM_REQ-1:0]          pick_gnt;
  logic [LP_ID_W-1:0]            pick_idx;
  logic                          accept;
  logic                          release_grant;
  logic                          limit_hit;

  logic                          m_valid_q;
  logic [C_AXIS_TDATA_WIDTH-1:0] m_data_q;
  logic [LP_KW-1:0]              m_keep_q;
  logic                          m_last_q;
  logic [LP_ID_W-1:0]            m_dest_q;
  logic [C_ADDER_BIT_WIDTH-1:0]  m_const_q;

  logic [C_AXIS_TDATA_WIDTH-1:0] data_arr  [C_NUM_REQ];
  logic [LP_KW-1:0]              keep_arr  [C_NUM_REQ];
  logic [C_ADDER_BIT_WIDTH-1:0]  const_arr [C_NUM_REQ];

  for (genvar gi = 0; gi < C_NUM_REQ; gi++) begin : g_slice
    assign data_arr[gi]  = s_axis_tdata[gi*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
    assign keep_arr[gi]  = s_axis_tkeep[gi*LP_KW +: LP_KW];
    assign const_arr[gi] = ctrl_constants[gi*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH];
  end

  vadd_rr_pick #(
    .N   (C_NUM_REQ),
    .IDW (LP_ID_W)
  ) u_pick (
    .req_i (s_axis_tvalid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign accept        = |(s_axis_tvalid & s_axis_tready);
  assign release_grant = accept & (s_axis_tlast[gidx_q] | limit_hit);

`ifdef ARB_BEAT_LIMIT_EN
  localparam int unsigned LP_CNT_W = (clog2_min1(C_MAX_BURST_BEATS + 1) > 9) ?
                                      clog2_min1(C_MAX_BURST_BEATS + 1) : 9;
  logic [LP_CNT_W-1:0] cnt_q;

  assign limit_hit = (cnt_q == LP_CNT_W'(C_MAX_BURST_BEATS - 1));

  always_ff @(posedge aclk) begin
    if (!aresetn) cnt_q <= '0;
    else if (accept) cnt_q <= release_grant ? '0 : cnt_q + LP_CNT_W'(1);
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|s_axis_tvalid) state_d = ST_BUSY;
      default: if (release_grant)  state_d = ST_IDLE;
    endcase
  end

  // Reset gating keeps every ready low while aresetn is asserted.
  always_comb begin
    s_axis_tready = '0;
    if (aresetn && state_q == ST_BUSY && (!m_valid_q || m_axis_tready))
      s_axis_tready = grant_q;
  end

  always_comb begin
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    if (state_q == ST_IDLE && |s_axis_tvalid) begin
      grant_d = pick_gnt;
      gidx_d  = pick_idx;
    end
    if (release_grant) begin
      grant_d = '0;
      ptr_d   = (gidx_q == LP_ID_W'(C_NUM_REQ - 1)) ? '0 : gidx_q + LP_ID_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  // A load while draining keeps valid high, giving one beat per cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_dest_q  <= '0;
      m_const_q <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= data_arr[gidx_q];
      m_keep_q  <= keep_arr[gidx_q];
      m_last_q  <= s_axis_tlast[gidx_q];
      m_dest_q  <= gidx_q;
      m_const_q <= const_arr[gidx_q];
    end else if (m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid   = m_valid_q;
  assign m_axis_tdata    = m_data_q;
  assign m_axis_tkeep    = m_keep_q;
  assign m_axis_tlast    = m_last_q;
  assign m_axis_tdest    = m_dest_q;
  assign m_ctrl_constant = m_const_q;
  assign arb_grant       = grant_q;

endmodule

// File: tb/tb_vadd_stream_arbiter.sv
// Directed bench for vadd_stream_arbiter: a per-cycle vector table for reset,
// round-robin order and wrap, plus sequences for backpressure, mid-packet reset and beat limit.
module tb_vadd_stream_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CB = 32;
  localparam int KW = W / 8;

  logic              clk = 1'b0;
  logic              aresetn;
  logic [N*CB-1:0]   ctrl_constants;
  logic [N-1:0]      s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [N*W-1:0]    s_axis_tdata;
  logic [N*KW-1:0]   s_axis_tkeep;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [W-1:0]      m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [1:0]        m_axis_tdest;
  logic [CB-1:0]     m_ctrl_constant;
  logic [N-1:0]      arb_grant;

  always #5 clk = ~clk;

  vadd_stream_arbiter #(
    .C_NUM_REQ(N), .C_AXIS_TDATA_WIDTH(W), .C_ADDER_BIT_WIDTH(CB), .C_MAX_BURST_BEATS(4)
  ) dut (
    .aclk(clk), .aresetn(aresetn), .ctrl_constants(ctrl_constants),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest), .m_ctrl_constant(m_ctrl_constant), .arb_grant(arb_grant)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic       rstn;
    logic [3:0] vld, last;
    logic       mrdy;
    logic [3:0] srdy;
    logic       mvld;
    logic [1:0] dest;
    logic       mlast;
    logic [3:0] gnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic [3:0] vl, logic [3:0] la, logic mr,
                             logic [3:0] sr, logic mv, logic [1:0] de, logic ml, logic [3:0] gn);
    vec_t x;
    x.rstn = r; x.vld = vl; x.last = la; x.mrdy = mr;
    x.srdy = sr; x.mvld = mv; x.dest = de; x.mlast = ml; x.gnt = gn;
    return x;
  endfunction

  // ---------------- sequence driver and monitor ----------------
  typedef struct { int dest; logic [W-1:0] data; logic [KW-1:0] keep; logic last; logic [CB-1:0] cnst; int cyc; } beat_t;
  typedef struct { int req; int bi; bit last; } exp_t;

  int         len[N], idx[N];
  bit         nolast[N];
  bit         bp;
  int         cyc;
  logic [3:0] pat = 4'b1001;
  beat_t      log_q[$];
  exp_t       exp_q[$];
  bit         hold;
  logic [70:0] saved;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i]            = idx[i] < len[i];
      s_axis_tlast[i]             = !nolast[i] && (idx[i] == len[i] - 1);
      s_axis_tdata[i*W +: W]      = {8'(8'hB0 + i), 24'(idx[i])};
      s_axis_tkeep[i*KW +: KW]    = 4'(idx[i] + i);
      ctrl_constants[i*CB +: CB]  = 32'((i + 1) * 256 + idx[i]);
    end
    m_axis_tready = bp ? pat[cyc % 4] : 1'b1;
  endtask

  task automatic step();
    logic [N-1:0] hs;
    beat_t b;
    @(negedge clk);
    hs = s_axis_tvalid & s_axis_tready;
    if (hold) begin
      chk("stall_valid", 128'(m_axis_tvalid), 128'(1));
      chk("stall_stable", 128'({m_axis_tdest, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_ctrl_constant}), 128'(saved));
    end
    if (m_axis_tvalid && m_axis_tready) begin
      b.dest = int'(m_axis_tdest); b.data = m_axis_tdata; b.keep = m_axis_tkeep;
      b.last = m_axis_tlast; b.cnst = m_ctrl_constant; b.cyc = cyc;
      log_q.push_back(b);
    end
    hold  = m_axis_tvalid && !m_axis_tready;
    saved = {m_axis_tdest, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_ctrl_constant};
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (hs[i]) idx[i]++;
    cyc++;
    drive();
  endtask

  task automatic run_until(input string name, input int n, input int limit);
    int k;
    k = 0;
    while (log_q.size() < n && k < limit) begin step(); k++; end
    if (log_q.size() < n) chk({name, "_timeout"}, 128'(log_q.size()), 128'(n));
    repeat (6) step();
  endtask

  task automatic expect_pkt(input int req, input int first, input int n, input bit lastflag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.req = req; e.bi = first + i; e.last = lastflag && (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_log(input string name);
    logic [127:0] a, r;
    int n;
    chk({name, "_count"}, 128'(log_q.size()), 128'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      a = {2'(log_q[i].dest), log_q[i].data, log_q[i].keep, log_q[i].last, log_q[i].cnst};
      r = {2'(exp_q[i].req), 8'(8'hB0 + exp_q[i].req), 24'(exp_q[i].bi), 4'(exp_q[i].bi + exp_q[i].req),
           exp_q[i].last, 32'((exp_q[i].req + 1) * 256 + exp_q[i].bi)};
      chk($sformatf("%s_beat%0d", name, i), a, r);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bp = 1'b0; cyc = 0;
    for (int i = 0; i < N; i++) begin len[i] = 0; idx[i] = 0; nolast[i] = 1'b0; end
    drive();
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    log_q.delete(); exp_q.delete(); hold = 1'b0;
  endtask

  initial begin
    vec_t t;
    int   k;

    // Reset with every requester valid, then four 3-beat packets (constants 1..4).
    repeat (4) tbl.push_back(v(0, 4'hF, 4'h0, 1, 4'h0, 0, 0, 0, 4'h0));
    tbl.push_back(v(1, 4'hF, 4'h0, 1, 4'h0, 0, 0, 0, 4'h0));
    tbl.push_back(v(1, 4'hF, 4'h0, 1, 4'h1, 0, 0, 0, 4'h1));
    tbl.push_back(v(1, 4'hF, 4'h0, 1, 4'h1, 1, 0, 0, 4'h1));
    tbl.push_back(v(1, 4'hF, 4'h1, 1, 4'h1, 1, 0, 0, 4'h1));
    tbl.push_back(v(1, 4'hE, 4'h0, 1, 4'h0, 1, 0, 1, 4'h0));
    tbl.push_back(v(1, 4'hE, 4'h0, 1, 4'h2, 0, 0, 0, 4'h2));
    tbl.push_back(v(1, 4'hE, 4'h0, 1, 4'h2, 1, 1, 0, 4'h2));
    tbl.push_back(v(1, 4'hE, 4'h2, 1, 4'h2, 1, 1, 0, 4'h2));
    tbl.push_back(v(1, 4'hC, 4'h0, 1, 4'h0, 1, 1, 1, 4'h0));
    tbl.push_back(v(1, 4'hC, 4'h0, 1, 4'h4, 0, 0, 0, 4'h4));
    tbl.push_back(v(1, 4'hC, 4'h0, 1, 4'h4, 1, 2, 0, 4'h4));
    tbl.push_back(v(1, 4'hC, 4'h4, 1, 4'h4, 1, 2, 0, 4'h4));
    tbl.push_back(v(1, 4'h8, 4'h0, 1, 4'h0, 1, 2, 1, 4'h0));
    tbl.push_back(v(1, 4'h8, 4'h0, 1, 4'h8, 0, 0, 0, 4'h8));
    tbl.push_back(v(1, 4'h8, 4'h0, 1, 4'h8, 1, 3, 0, 4'h8));
    tbl.push_back(v(1, 4'h8, 4'h8, 1, 4'h8, 1, 3, 0, 4'h8));
    tbl.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 1, 3, 1, 4'h0));
    tbl.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 4'h0));
    // Wrap: req3 alone, then req0 beats a waiting req3, then req3 again.
    tbl.push_back(v(1, 4'h8, 4'h8, 1, 4'h0, 0, 0, 0, 4'h0));
    tbl.push_back(v(1, 4'h8, 4'h8, 1, 4'h8, 0, 0, 0, 4'h8));
    tbl.push_back(v(1, 4'h9, 4'h9, 1, 4'h0, 1, 3, 1, 4'h0));
    tbl.push_back(v(1, 4'h9, 4'h9, 1, 4'h1, 0, 0, 0, 4'h1));
    tbl.push_back(v(1, 4'h8, 4'h8, 1, 4'h0, 1, 0, 1, 4'h0));
    tbl.push_back(v(1, 4'h8, 4'h8, 1, 4'h8, 0, 0, 0, 4'h8));
    tbl.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 1, 3, 1, 4'h0));
    tbl.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 4'h0));

    aresetn = 1'b0; s_axis_tvalid = '0; s_axis_tlast = '0; m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_axis_tdata[i*W +: W]     = {8'(8'hA0 + i), 24'h0};
      s_axis_tkeep[i*KW +: KW]   = 4'hF;
      ctrl_constants[i*CB +: CB] = 32'(i + 1);
    end
    hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < tbl.size(); n++) begin
      t = tbl[n];
      aresetn = t.rstn; s_axis_tvalid = t.vld; s_axis_tlast = t.last; m_axis_tready = t.mrdy;
      @(negedge clk);
      chk($sformatf("vec%0d_srdy", n), 128'(s_axis_tready), 128'(t.srdy));
      chk($sformatf("vec%0d_mvld", n), 128'(m_axis_tvalid), 128'(t.mvld));
      chk($sformatf("vec%0d_gnt", n),  128'(arb_grant),     128'(t.gnt));
      if (!t.rstn)
        chk($sformatf("vec%0d_rst_fields", n), 128'({m_axis_tdata, m_ctrl_constant, m_axis_tdest}), 128'(0));
      if (t.mvld) begin
        chk($sformatf("vec%0d_dest", n),  128'(m_axis_tdest),    128'(t.dest));
        chk($sformatf("vec%0d_data", n),  128'(m_axis_tdata),    128'({8'(8'hA0 + t.dest), 24'h0}));
        chk($sformatf("vec%0d_const", n), 128'(m_ctrl_constant), 128'(32'(t.dest + 1)));
        chk($sformatf("vec%0d_last", n),  128'(m_axis_tlast),    128'(t.mlast));
      end
      @(posedge clk); #1;
    end

    // Backpressure on an 8-beat req2 packet, then back-to-back req3 / single-beat req0.
    do_reset();
    len[2] = 8; bp = 1'b1; drive();
    run_until("bp", 8, 100);
    bp = 1'b0; len[3] = 2; len[0] = 1; drive();
    run_until("b2b", 11, 40);
    expect_pkt(2, 0, 8, 1); expect_pkt(3, 0, 2, 1); expect_pkt(0, 0, 1, 1);
    check_log("bp");
    if (log_q.size() >= 10) chk("b2b_rate", 128'(log_q[9].cyc - log_q[8].cyc), 128'(1));

    // Reset while req1 is on beat 2 of 5; req0 must win after release.
    do_reset();
    len[1] = 5; drive();
    k = 0;
    while (idx[1] < 2 && k < 30) begin step(); k++; end
    chk("mid_rst_reach", 128'(idx[1]), 128'(2));
    aresetn = 1'b0;
    step();
    log_q.delete(); hold = 1'b0;
    @(negedge clk);
    chk("mid_rst_mvld", 128'(m_axis_tvalid), 128'(0));
    chk("mid_rst_srdy", 128'(s_axis_tready), 128'(0));
    chk("mid_rst_gnt",  128'(arb_grant),     128'(0));
    aresetn = 1'b1; len[0] = 2; drive();
    run_until("mid_rst", 5, 40);
    expect_pkt(0, 0, 2, 1); expect_pkt(1, 2, 3, 1);
    check_log("mid_rst");

    // req0 streams 10 beats with no tlast while req1 waits.
    do_reset();
    len[0] = 10; nolast[0] = 1'b1; len[1] = 3; drive();
`ifdef ARB_BEAT_LIMIT_EN
    expect_pkt(0, 0, 4, 0); expect_pkt(1, 0, 3, 1); expect_pkt(0, 4, 4, 0); expect_pkt(0, 8, 2, 0);
`else
    expect_pkt(0, 0, 10, 0);
`endif
    run_until("limit", exp_q.size(), 80);
    check_log("limit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
